// File: rtl/trace_buffer_ctrl_if.sv
// Signal bundle between the trace-buffer sequencer, the debug host/trigger logic,
// the buffer read port and the dump consumer.
interface trace_buffer_ctrl_if #(
    parameter int N          = 8,
    parameter int DATA_WIDTH = 32,
    parameter int TB_SIZE    = 64
);
    localparam int AW = $clog2(TB_SIZE);
    localparam int CW = $clog2(TB_SIZE + 1);
    localparam int DW = N * DATA_WIDTH;

    logic          arm;
    logic          trigger;
    logic [CW-1:0] post_count;
    logic          valid_in;
    logic          tracing;
    logic          dump_req;
    logic [AW-1:0] tb_rd_addr;
    logic          tb_rd_en;
    logic [DW-1:0] tb_rd_data;
    logic          dump_valid;
    logic          dump_ready;
    logic [DW-1:0] dump_data;
    logic          dump_last;
    logic          dump_done;
    logic [CW-1:0] fill_count;
    logic          busy;

    modport master (
        output arm, trigger, post_count, valid_in, dump_req, tb_rd_data, dump_ready,
        input  tracing, tb_rd_addr, tb_rd_en, dump_valid, dump_data, dump_last,
               dump_done, fill_count, busy
    );

    modport slave (
        input  arm, trigger, post_count, valid_in, dump_req, tb_rd_data, dump_ready,
        output tracing, tb_rd_addr, tb_rd_en, dump_valid, dump_data, dump_last,
               dump_done, fill_count, busy
    );
endinterface

// File: rtl/trace_buffer_ctrl.sv
// Capture/dump sequencer for the circular trace buffer: arms capture, counts a
// post-trigger window, freezes, then streams the frozen contents oldest-first.
module trace_buffer_ctrl #(
    parameter int N            = 8,
    parameter int DATA_WIDTH   = 32,
    parameter int TB_SIZE      = 64,
    parameter int READ_LATENCY = 1,
    parameter int WR_PTR_INIT  = 1
) (
    input logic clk,
    input logic reset,
    trace_buffer_ctrl_if.slave bus
);
    localparam int AW     = $clog2(TB_SIZE);
    localparam int CW     = $clog2(TB_SIZE + 1);
    localparam int DW     = N * DATA_WIDTH;
    localparam int FDEPTH = READ_LATENCY + 1;
    localparam int FAW    = $clog2(FDEPTH);
    localparam int OW     = $clog2(FDEPTH + 1);

    typedef enum logic [2:0] {IDLE, ARMED, POST, FROZEN, DUMP} state_t;

    state_t                  state, state_nxt;
    logic [AW-1:0]           wr_ptr, rd_addr;
    logic [CW-1:0]           fill_count, cnt, issued, beat_cnt;
    logic [READ_LATENCY-1:0] tag_pipe;
    logic [OW-1:0]           in_flight, fifo_occ;
    logic [FAW-1:0]          fifo_head, fifo_tail;
    logic [DW-1:0]           fifo_mem [FDEPTH];
    logic tracing, write_hit, fifo_valid, last, pop, ret, issue, room;
    logic enter_armed, enter_dump, done;

    function automatic logic [FAW-1:0] fifo_next(input logic [FAW-1:0] p);
        return (p == FAW'(FDEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign tracing    = (state == ARMED) || (state == POST);
    assign write_hit  = tracing && bus.valid_in;
    assign fifo_valid = (fifo_occ != '0);
    assign last       = fifo_valid && (beat_cnt == fill_count - CW'(1));
    assign pop        = fifo_valid && bus.dump_ready;
    assign ret        = tag_pipe[READ_LATENCY-1];

    // A beat leaving this cycle frees its slot, which keeps the stream at one beat per cycle.
    always_comb begin
        room  = (int'(in_flight) + int'(fifo_occ) - int'(pop)) < FDEPTH;
        issue = (state == DUMP) && (issued < fill_count) && room;
    end

    always_comb begin
        state_nxt   = state;
        enter_armed = 1'b0;
        enter_dump  = 1'b0;
        done        = 1'b0;
        unique case (state)
            IDLE: if (bus.arm) begin
                state_nxt   = ARMED;
                enter_armed = 1'b1;
            end
            ARMED: if (bus.trigger) state_nxt = (bus.post_count == '0) ? FROZEN : POST;
            POST: if (bus.valid_in && cnt == CW'(1)) state_nxt = FROZEN;
            FROZEN: if (bus.dump_req) begin
                state_nxt  = DUMP;
                enter_dump = 1'b1;
            end else if (bus.arm) begin
                state_nxt   = ARMED;
                enter_armed = 1'b1;
            end
            DUMP: if (fill_count == '0 || (pop && last)) begin
                state_nxt = IDLE;
                done      = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            wr_ptr     <= AW'(WR_PTR_INIT);
            fill_count <= '0;
            cnt        <= '0;
            rd_addr    <= '0;
            issued     <= '0;
            beat_cnt   <= '0;
            tag_pipe   <= '0;
            in_flight  <= '0;
            fifo_occ   <= '0;
            fifo_head  <= '0;
            fifo_tail  <= '0;
        end else begin
            state <= state_nxt;
            if (write_hit) wr_ptr <= wr_ptr + 1'b1;
            if (enter_armed) fill_count <= '0;
            else if (write_hit && fill_count != CW'(TB_SIZE)) fill_count <= fill_count + 1'b1;
            if (state == ARMED && bus.trigger) cnt <= bus.post_count;
            else if (state == POST && bus.valid_in) cnt <= cnt - 1'b1;
            // Oldest entry: a full buffer truncates fill_count to 0, giving wr_ptr itself.
            if (enter_dump) begin
                rd_addr  <= wr_ptr - AW'(fill_count);
                issued   <= '0;
                beat_cnt <= '0;
            end else begin
                if (issue) begin
                    rd_addr <= rd_addr + 1'b1;
                    issued  <= issued + 1'b1;
                end
                if (pop) beat_cnt <= beat_cnt + 1'b1;
            end
            tag_pipe  <= (tag_pipe << 1) | READ_LATENCY'(issue);
            in_flight <= in_flight + OW'(issue) - OW'(ret);
            fifo_occ  <= fifo_occ + OW'(ret) - OW'(pop);
            if (ret) fifo_tail <= fifo_next(fifo_tail);
            if (pop) fifo_head <= fifo_next(fifo_head);
        end
    end

    always_ff @(posedge clk) begin
        if (ret) fifo_mem[fifo_tail] <= bus.tb_rd_data;
    end

    assign bus.tracing    = tracing;
    assign bus.busy       = (state != IDLE);
    assign bus.fill_count = fill_count;
    assign bus.tb_rd_addr = rd_addr;
    assign bus.tb_rd_en   = issue;
    assign bus.dump_valid = fifo_valid;
    assign bus.dump_data  = fifo_valid ? fifo_mem[fifo_head] : '0;
    assign bus.dump_last  = last;
    assign bus.dump_done  = done;
endmodule

// File: tb/tb_trace_buffer_ctrl.sv
// Bench for trace_buffer_ctrl: models the trace buffer around the DUT and checks
// each dump against a queue of the writes captured since the last arm.
module tb_trace_buffer_ctrl;
    localparam int N            = 2;
    localparam int DATA_WIDTH   = 8;
    localparam int TB_SIZE      = 8;
    localparam int READ_LATENCY = 1;
    localparam int WR_PTR_INIT  = 1;
    localparam int DW = N * DATA_WIDTH;
    localparam int AW = $clog2(TB_SIZE);
    localparam int CW = $clog2(TB_SIZE + 1);

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    trace_buffer_ctrl_if #(.N(N), .DATA_WIDTH(DATA_WIDTH), .TB_SIZE(TB_SIZE)) bus ();

    trace_buffer_ctrl #(
        .N(N), .DATA_WIDTH(DATA_WIDTH), .TB_SIZE(TB_SIZE),
        .READ_LATENCY(READ_LATENCY), .WR_PTR_INIT(WR_PTR_INIT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] wdata;
    logic [DW-1:0] mem [TB_SIZE];
    logic [AW-1:0] bwp;
    logic [DW-1:0] q[$];
    int            wp;
    int            addr_q[$];
    logic [DW-1:0] stall_data;
    logic          stall_last;
    logic          stall_prev = 1'b0;
    logic          rst_prev   = 1'b1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    // Trace buffer: write side fed while tracing, port B with one cycle of read latency.
    always @(posedge clk) begin
        if (reset) bwp <= AW'(WR_PTR_INIT);
        else if (bus.tracing && bus.valid_in) begin
            mem[bwp] <= wdata;
            bwp      <= bwp + 1'b1;
        end
        bus.tb_rd_data <= mem[bus.tb_rd_addr];
    end

    always @(negedge clk) begin
        if (bus.tb_rd_en) addr_q.push_back(int'(bus.tb_rd_addr));
        if (stall_prev && !rst_prev) begin
            chk("stall_valid", 32'(bus.dump_valid), 32'd1);
            chk("stall_data", 32'(bus.dump_data), 32'(stall_data));
            chk("stall_last", 32'(bus.dump_last), 32'(stall_last));
        end
        stall_prev <= bus.dump_valid && !bus.dump_ready;
        stall_data <= bus.dump_data;
        stall_last <= bus.dump_last;
        rst_prev   <= reset;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic gap();
        repeat ($urandom_range(0, 2)) tick();
    endtask

    task automatic wr(input bit keep);
        wdata = DW'($urandom);
        bus.valid_in = 1'b1;
        if (keep) begin
            q.push_back(wdata);
            wp = (wp + 1) % TB_SIZE;
        end
        tick();
        bus.valid_in = 1'b0;
    endtask

    task automatic capture(input int pre, input int post, input bit overlap, input bit stray);
        int expf;
        bus.arm = 1'b1;
        tick();
        bus.arm = 1'b0;
        q.delete();
        chk("armed_tracing", 32'(bus.tracing), 32'd1);
        chk("armed_fill", 32'(bus.fill_count), 32'd0);
        for (int i = 0; i < pre - int'(overlap); i++) begin
            gap();
            wr(1'b1);
        end
        gap();
        bus.trigger    = 1'b1;
        bus.post_count = CW'(post);
        if (overlap) wr(1'b1);
        else tick();
        bus.trigger    = 1'b0;
        bus.post_count = CW'($urandom);
        chk("trig_tracing", 32'(bus.tracing), (post > 0) ? 32'd1 : 32'd0);
        for (int i = 1; i <= post; i++) begin
            gap();
            if (stray && i == 1) begin
                bus.trigger = 1'b1;
                tick();
                bus.trigger = 1'b0;
            end
            wr(1'b1);
            chk("post_tracing", 32'(bus.tracing), (i < post) ? 32'd1 : 32'd0);
        end
        gap();
        wr(1'b0);
        expf = (q.size() < TB_SIZE) ? q.size() : TB_SIZE;
        chk("frozen_fill", 32'(bus.fill_count), 32'(expf));
        chk("frozen_busy", 32'(bus.busy), 32'd1);
    endtask

    task automatic dump(input int mode, input bit arm_with_req, input int abort_after);
        int n, c, done_c;
        bit done;
        logic [DW-1:0] beats[$];
        bit lasts[$];
        n = (q.size() < TB_SIZE) ? q.size() : TB_SIZE;
        addr_q.delete();
        bus.dump_ready = 1'b0;
        bus.dump_req   = 1'b1;
        bus.arm        = arm_with_req;
        tick();
        bus.dump_req = 1'b0;
        bus.arm      = 1'b0;
        done   = 1'b0;
        done_c = -1;
        c      = 0;
        while (!done && c < 200) begin
            bus.dump_ready = (mode == 0) ? 1'b1 : (mode == 1) ? (c % 2 == 0) : 1'($urandom_range(0, 1));
            if (mode == 2 && c == 3) begin
                bus.arm      = 1'b1;
                bus.trigger  = 1'b1;
                bus.dump_req = 1'b1;
            end
            @(negedge clk);
            if (bus.dump_valid && bus.dump_ready) begin
                beats.push_back(bus.dump_data);
                lasts.push_back(bus.dump_last);
            end
            if (bus.dump_done) begin
                done   = 1'b1;
                done_c = c;
            end
            tick();
            bus.arm      = 1'b0;
            bus.trigger  = 1'b0;
            bus.dump_req = 1'b0;
            c++;
            if (abort_after > 0 && beats.size() == abort_after) break;
        end
        bus.dump_ready = 1'b0;
        if (abort_after > 0) begin
            chk("abort_beats", 32'(beats.size()), 32'(abort_after));
            for (int i = 0; i < beats.size(); i++)
                chk("abort_data", 32'(beats[i]), 32'(q[q.size() - n + i]));
            reset = 1'b1;
            tick();
            reset = 1'b0;
            q.delete();
            wp = WR_PTR_INIT;
            chk("abort_valid", 32'(bus.dump_valid), 32'd0);
            chk("abort_busy", 32'(bus.busy), 32'd0);
            chk("abort_fill", 32'(bus.fill_count), 32'd0);
            chk("abort_tracing", 32'(bus.tracing), 32'd0);
        end else begin
            chk("dump_done_seen", 32'(done), 32'd1);
            chk("beat_count", 32'(beats.size()), 32'(n));
            for (int i = 0; i < beats.size() && i < n; i++) begin
                chk("beat_data", 32'(beats[i]), 32'(q[q.size() - n + i]));
                chk("beat_last", 32'(lasts[i]), (i == n - 1) ? 32'd1 : 32'd0);
            end
            chk("addr_count", 32'(addr_q.size()), 32'(n));
            for (int i = 0; i < addr_q.size() && i < n; i++)
                chk("rd_addr", 32'(addr_q[i]), 32'((wp - n + i + 2 * TB_SIZE) % TB_SIZE));
            if (mode == 0) chk("done_cycle", 32'(done_c), (n == 0) ? 32'd0 : 32'(n + 1));
            chk("post_dump_busy", 32'(bus.busy), 32'd0);
            chk("post_dump_valid", 32'(bus.dump_valid), 32'd0);
        end
    endtask

    initial begin
        reset          = 1'b1;
        bus.arm        = 1'b0;
        bus.trigger    = 1'b0;
        bus.post_count = '0;
        bus.valid_in   = 1'b0;
        bus.dump_req   = 1'b0;
        bus.dump_ready = 1'b0;
        wdata          = '0;
        wp             = WR_PTR_INIT;
        repeat (3) tick();
        reset = 1'b0;
        chk("rst_tracing", 32'(bus.tracing), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_fill", 32'(bus.fill_count), 32'd0);
        chk("rst_rd_addr", 32'(bus.tb_rd_addr), 32'd0);
        chk("rst_rd_en", 32'(bus.tb_rd_en), 32'd0);
        chk("rst_dump_valid", 32'(bus.dump_valid), 32'd0);
        chk("rst_dump_data", 32'(bus.dump_data), 32'd0);
        chk("rst_dump_last", 32'(bus.dump_last), 32'd0);
        chk("rst_dump_done", 32'(bus.dump_done), 32'd0);

        // basic capture: 3 pre + 2 post, full-rate dump
        capture(3, 2, 1'b0, 1'b0);
        dump(0, 1'b0, 0);

        // wrap-around from a fresh reset; arm alongside dump_req must lose
        reset = 1'b1;
        tick();
        reset = 1'b0;
        wp = WR_PTR_INIT;
        capture(11, 0, 1'b0, 1'b0);
        dump(0, 1'b1, 0);

        // alternating backpressure
        capture(2, 3, 1'b0, 1'b1);
        dump(1, 1'b0, 0);

        // trigger and write in the same cycle, then a one-write window
        capture(2, 1, 1'b1, 1'b0);
        dump(2, 1'b0, 0);

        // re-arm from FROZEN discards the first capture
        capture(4, 2, 1'b0, 1'b0);
        capture(1, 1, 1'b0, 1'b0);
        dump(0, 1'b0, 0);

        // reset after two accepted beats, then a dump request with nothing armed
        capture(3, 3, 1'b0, 1'b0);
        dump(0, 1'b0, 2);
        addr_q.delete();
        bus.dump_req = 1'b1;
        tick();
        bus.dump_req = 1'b0;
        repeat (3) tick();
        chk("idle_req_busy", 32'(bus.busy), 32'd0);
        chk("idle_req_reads", 32'(addr_q.size()), 32'd0);
        chk("idle_req_valid", 32'(bus.dump_valid), 32'd0);

        // empty capture
        capture(0, 0, 1'b0, 1'b0);
        dump(0, 1'b0, 0);

        // randomized captures and dumps
        for (int it = 0; it < 8; it++) begin
            int pre, post;
            bit ov, st;
            pre  = $urandom_range(0, 12);
            post = $urandom_range(0, 8);
            ov   = (pre > 0) && ($urandom_range(0, 1) == 1);
            st   = (post > 0) && ($urandom_range(0, 1) == 1);
            capture(pre, post, ov, st);
            dump($urandom_range(0, 2), 1'($urandom_range(0, 1)), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
